// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional bubble counter enabled by defining ID_EX_PERF_CNT_EN; otherwise bubble_cnt is tied to zero.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [18:0] id_ctrl,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_pc4,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [4:0]  id_shamt,
  input  logic        flush,
  input  logic        hold,
  output logic        ex_valid,
  output logic [18:0] ex_ctrl,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_pc4,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_shamt,
  output logic        lu_stall,
  output logic [31:0] bubble_cnt
);

  logic        valid_q, valid_d;
  logic [18:0] ctrl_q, ctrl_d;
  logic [31:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic [31:0] imm_q, imm_d, pc4_q, pc4_d;
  logic [4:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, shamt_q, shamt_d;
  logic        hazard;
  logic        load_bubble;

  // A load in EX whose destination is read by the instruction in ID; $zero never conflicts.
  assign hazard = valid_q & ctrl_q[6] & (rt_q != 5'd0) & id_valid &
                  ((rt_q == id_rs) | (rt_q == id_rt));
  assign lu_stall    = hazard & ~hold;
  assign load_bubble = ~hold & (flush | lu_stall);

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    pc4_d     = pc4_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    shamt_d   = shamt_q;
    if (!hold) begin
      if (load_bubble) begin
        valid_d   = 1'b0;
        ctrl_d    = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        pc4_d     = '0;
        rs_d      = '0;
        rt_d      = '0;
        rd_d      = '0;
        shamt_d   = '0;
      end else begin
        valid_d   = id_valid;
        ctrl_d    = id_valid ? id_ctrl : 19'd0;
        rs_data_d = id_rs_data;
        rt_data_d = id_rt_data;
        imm_d     = id_imm;
        pc4_d     = id_pc4;
        rs_d      = id_rs;
        rt_d      = id_rt;
        rd_d      = id_rd;
        shamt_d   = id_shamt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      pc4_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      shamt_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      pc4_q     <= pc4_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      shamt_q   <= shamt_d;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_bubble) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bubble_cnt = cnt_q;
`else
  assign bubble_cnt = 32'h0;
`endif

  assign ex_valid   = valid_q;
  assign ex_ctrl    = ctrl_q;
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_imm     = imm_q;
  assign ex_pc4     = pc4_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_rd      = rd_q;
  assign ex_shamt   = shamt_q;

endmodule
